axis_rr_merge: RTL
==================

AXIS_RR_MERGE -- requirements
Module: axis_rr_merge

Interface
REQ-001 Parameters SHALL be:
  - DATA_WIDTH, default 16, data bits per beat.
  - IF_STREAM, default 1: 1 = multi-beat frames delimited by tlast; 0 = every beat is a complete frame.
  - KEEP_WIDTH, default IF_STREAM ? DATA_WIDTH/8 : 1, byte-enable bits per beat.
  - PORT_COUNT, default 2, number of requesting input streams (at least 2).
  - ID_WIDTH, default $clog2(PORT_COUNT), width of the source index.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1: single clock; all logic is on the rising edge.
  - rst, in, 1: reset, synchronous, active-high.
  - s_axis_in_tdata, in, PORT_COUNT*DATA_WIDTH: port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
  - s_axis_in_tkeep, in, PORT_COUNT*KEEP_WIDTH: per-port keep.
  - s_axis_in_tvalid, in, PORT_COUNT: per-port valid.
  - s_axis_in_tlast, in, PORT_COUNT: per-port last.
  - s_axis_in_tready, out, PORT_COUNT: per-port ready.
  - m_axis_out_tdata, out, DATA_WIDTH: merged data.
  - m_axis_out_tkeep, out, KEEP_WIDTH: merged keep.
  - m_axis_out_tvalid, out, 1: merged valid.
  - m_axis_out_tlast, out, 1: merged last.
  - m_axis_out_tid, out, ID_WIDTH: index of the source port of the current beat.
  - m_axis_out_tready, in, 1: downstream ready.

Function
REQ-003 The block SHALL merge PORT_COUNT input streams onto one output using round-robin arbitration at frame granularity.
REQ-004 The controller SHALL use two states:
  - IDLE: no grant held.
  - BUSY: grant register g holds the index of the owning port.
REQ-005 In IDLE, when any s_axis_in_tvalid bit is 1, the block SHALL select the first asserted port searching upward from last_grant+1, wrapping modulo PORT_COUNT. It SHALL load g with that port and enter BUSY on the next edge. This arbitration costs exactly one cycle per frame.
REQ-006 In IDLE with no valid asserted, the block SHALL remain in IDLE, and last_grant SHALL be unchanged.
REQ-007 s_axis_in_tready[p] SHALL be 1 only when all of the following hold: state is BUSY, p == g, and (m_axis_out_tvalid == 0 or m_axis_out_tready == 1). Every other port's ready SHALL be 0.
REQ-008 The output SHALL be a single register stage.
  - On an accepted input beat, tdata, tkeep, tlast and tid = g SHALL be loaded, and m_axis_out_tvalid set to 1.
  - Latency is 1 cycle from input handshake to output valid.
REQ-009 When m_axis_out_tready is 1 and no new beat is loaded, m_axis_out_tvalid SHALL clear to 0.
REQ-010 While m_axis_out_tvalid is 1 and m_axis_out_tready is 0, all output fields SHALL hold stable.
REQ-011 When IF_STREAM = 0:
  - the effective tlast SHALL be 1 on every beat;
  - the effective tkeep SHALL be all ones;
  - the input tlast and tkeep SHALL be ignored.
REQ-012 On acceptance of a beat whose effective tlast is 1, the block SHALL set last_grant = g and return to IDLE on the same edge. The next frame is therefore granted no earlier than the following cycle.
REQ-013 In BUSY, deassertion of the owning port's tvalid mid-frame SHALL NOT release the grant. The block SHALL wait indefinitely for tlast, and other ports SHALL stay blocked.
REQ-014 The output SHALL never interleave beats from different frames, and every frame on the output SHALL carry a constant tid.
REQ-015 Arbitration SHALL be starvation-free: with all ports continuously valid, grants SHALL rotate 0, 1, ..., PORT_COUNT-1, 0, ...

Reset
REQ-016 While rst is 1 at a clock edge, the block SHALL:
  - set state to IDLE, g to 0, and last_grant to PORT_COUNT-1, so port 0 has highest priority;
  - drive m_axis_out_tvalid, tdata, tkeep, tlast and tid to 0;
  - drive all s_axis_in_tready bits to 0.
REQ-017 A reset asserted mid-frame SHALL abandon the partial frame with no further output beats. After rst deasserts, arbitration SHALL restart from port 0 priority.

Verification
REQ-018 The bench SHALL cover these directed scenarios (PORT_COUNT = 2, IF_STREAM = 1 unless stated):
  - Single frame: port 1 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), m_tready = 1 → the output shows those 3 beats with tid = 1 on consecutive cycles, first output valid 2 cycles after port 1 tvalid rises.
  - Contention: both ports valid, each with 2-beat frames, from reset → output order is port 0 frame, then port 1 frame, then port 0 frame; no interleave; one idle cycle between frames.
  - Backpressure: m_tready = 0 for 5 cycles mid-frame → output beat held stable; owning port's tready = 0 during the stall; no beat lost or duplicated.
  - Owner gap: port 0 drops tvalid for 3 cycles mid-frame while port 1 is valid → port 1 tready stays 0 until port 0's tlast is accepted.
  - IF_STREAM = 0: both ports continuously valid, single beats → tid alternates 0, 1, 0, 1; tlast = 1 and tkeep = 1 on every beat.
  - Reset mid-frame: rst pulsed for 1 cycle after 2 of 4 beats from port 1 → m_tvalid = 0 the next cycle; the next grant goes to port 0 when both ports are valid.

Source files
------------

// File: rtl/axis_rr_merge_if.sv
// axis_rr_merge_if: the PORT_COUNT input streams and the single merged output
// stream of axis_rr_merge, bundled so the merger and its environment share one
// set of declarations.
//   master : the merger's view (consumes input streams, produces the output)
//   slave  : the environment's view (produces input streams, consumes output)
interface axis_rr_merge_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IF_STREAM  = 1,
    parameter int KEEP_WIDTH = (IF_STREAM != 0) ? DATA_WIDTH / 8 : 1,
    parameter int PORT_COUNT = 2,
    parameter int ID_WIDTH   = $clog2(PORT_COUNT)
);

    // Input streams, port p in slice p of each flattened vector
    logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_in_tdata;
    logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_in_tkeep;
    logic [PORT_COUNT-1:0]            s_axis_in_tvalid;
    logic [PORT_COUNT-1:0]            s_axis_in_tlast;
    logic [PORT_COUNT-1:0]            s_axis_in_tready;

    // Merged output stream
    logic [DATA_WIDTH-1:0]            m_axis_out_tdata;
    logic [KEEP_WIDTH-1:0]            m_axis_out_tkeep;
    logic                             m_axis_out_tvalid;
    logic                             m_axis_out_tlast;
    logic [ID_WIDTH-1:0]              m_axis_out_tid;
    logic                             m_axis_out_tready;

    modport master (
        input  s_axis_in_tdata,
        input  s_axis_in_tkeep,
        input  s_axis_in_tvalid,
        input  s_axis_in_tlast,
        output s_axis_in_tready,
        output m_axis_out_tdata,
        output m_axis_out_tkeep,
        output m_axis_out_tvalid,
        output m_axis_out_tlast,
        output m_axis_out_tid,
        input  m_axis_out_tready
    );

    modport slave (
        output s_axis_in_tdata,
        output s_axis_in_tkeep,
        output s_axis_in_tvalid,
        output s_axis_in_tlast,
        input  s_axis_in_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tkeep,
        input  m_axis_out_tvalid,
        input  m_axis_out_tlast,
        input  m_axis_out_tid,
        output m_axis_out_tready
    );

endinterface

// File: rtl/axis_rr_merge.sv
// axis_rr_merge: merges PORT_COUNT AXI-Stream inputs onto one output with
// frame-granular round-robin arbitration. A grant is taken in IDLE (one cycle
// per frame), held in BUSY until the owning port's last beat is accepted, and
// every accepted beat passes through a single output register stage that
// carries the source index on tid.
module axis_rr_merge #(
    parameter int DATA_WIDTH = 16,
    parameter int IF_STREAM  = 1,
    parameter int KEEP_WIDTH = (IF_STREAM != 0) ? DATA_WIDTH / 8 : 1,
    parameter int PORT_COUNT = 2,
    parameter int ID_WIDTH   = $clog2(PORT_COUNT)
) (
    input logic             clk,
    input logic             rst,
    axis_rr_merge_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_WIDTH-1:0]   grant_q;
    logic [ID_WIDTH-1:0]   grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q;
    logic [ID_WIDTH-1:0]   last_grant_d;

    // Round-robin candidate search
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [ID_WIDTH-1:0]   cand;

    // Per-port views of the flattened input vectors
    logic [DATA_WIDTH-1:0] in_data [PORT_COUNT];
    logic [KEEP_WIDTH-1:0] in_keep [PORT_COUNT];

    // Beat selected from the owning port, after the IF_STREAM overrides
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_last;

    logic                  out_free;
    logic                  accept;
    logic [PORT_COUNT-1:0] tready_vec;

    // Output register stage
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [KEEP_WIDTH-1:0] out_keep_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [ID_WIDTH-1:0]   out_id_q;

    // Split the flattened input buses into per-port slices
    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            in_data[p] = bus.s_axis_in_tdata[p*DATA_WIDTH +: DATA_WIDTH];
            in_keep[p] = bus.s_axis_in_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        end
    end

    // First valid port searching upward from last_grant+1, wrapping around
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves it unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= PORT_COUNT; i++) begin
            cand = ID_WIDTH'((int'(last_grant_q) + i) % PORT_COUNT);
            if (!pick_found && bus.s_axis_in_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Owning port's beat; in single-beat mode every beat is a whole frame
    always_comb begin
        sel_data = in_data[grant_q];
        sel_keep = (IF_STREAM != 0) ? in_keep[grant_q] : '1;
        sel_last = (IF_STREAM != 0) ? bus.s_axis_in_tlast[grant_q] : 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(PORT_COUNT - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // FSM next-state: take a grant in IDLE, release it on an accepted last beat
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = pick_idx;
                end
            end
            BUSY: begin
                // An owner dropping tvalid mid-frame keeps the grant
                if (accept && sel_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: ready only to the owner, and only when the output slot frees
    always_comb begin
        out_free   = !out_valid_q || bus.m_axis_out_tready;
        tready_vec = '0;
        if (state_q == BUSY && out_free && !rst) begin
            tready_vec[grant_q] = 1'b1;
        end
        accept = tready_vec[grant_q] && bus.s_axis_in_tvalid[grant_q];
    end

    // Output register: load on accept, drain on downstream ready, else hold
    always_ff @(posedge clk) begin
        // NOTE: the output data fields are cleared in reset as well as valid,
        // so the bus reads all-zero while the block is held in reset.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_keep_q  <= sel_keep;
            out_last_q  <= sel_last;
            out_id_q    <= grant_q;
        end else if (bus.m_axis_out_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.s_axis_in_tready  = tready_vec;
    assign bus.m_axis_out_tdata  = out_data_q;
    assign bus.m_axis_out_tkeep  = out_keep_q;
    assign bus.m_axis_out_tvalid = out_valid_q;
    assign bus.m_axis_out_tlast  = out_last_q;
    assign bus.m_axis_out_tid    = out_id_q;

    // At most one input port is ever offered ready
    a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.s_axis_in_tready));

    // The grant is held until the owning frame's last beat is accepted
    a_grant_hold : assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY && !(accept && sel_last)) |=> (state_q == BUSY && $stable(grant_q)));

    // A stalled output beat stays put
    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        (bus.m_axis_out_tvalid && !bus.m_axis_out_tready) |=>
        (bus.m_axis_out_tvalid && $stable(bus.m_axis_out_tdata) && $stable(bus.m_axis_out_tid)));

endmodule
